// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit_pkg
// Description : Shared types and sizing for the gshare branch predictor and
//               the EX-stage branch resolution logic.
//               - br_check_type  : prediction made for one fetch
//               - br_update_type : resolution sent back from EX
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predict_unit_pkg;

  // Global history length; also the PHT index width.
  localparam int GSHARE_HISTORY_LENGTH = 8;

  // Prediction produced in IF and carried down the pipe with the instruction.
  typedef struct packed {
    logic                             branch_take;
    logic [1:0]                       GBP_predict;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR;
  } br_check_type;

  // Resolution from EX. GBHR_old is the history snapshot taken at fetch time,
  // so the PHT entry that produced the prediction is the one trained.
  typedef struct packed {
    logic                             update;
    logic                             actual;
    logic                             wrong;
    logic [GSHARE_HISTORY_LENGTH-1:0] GBHR_old;
    logic [1:0]                       GBP_predict_update;
  } br_update_type;

  // Reset value of every PHT counter: weakly not-taken.
  localparam logic [1:0] PHT_RESET_VALUE = 2'b01;

endpackage : branch_predict_unit_pkg
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit_if
// Description : Fetch/EX bundle of the branch predictor.
//   stall_if     : fetch stalled, freezes speculative history
//   pc_if        : fetch-stage PC
//   br_update_ex : branch resolution from EX
//   pc_ex        : PC of the resolving branch
//   actual_pc    : resolved branch target
//   br_check_if  : prediction for this fetch (take, counter, history)
//   predicted_pc : next fetch PC
//   master modport = pipeline side, slave modport = predictor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predict_unit_if #(
  parameter int PC_LENGTH = 32
);
  import branch_predict_unit_pkg::*;

  logic                 stall_if;
  logic [PC_LENGTH-1:0] pc_if;
  br_update_type        br_update_ex;
  logic [PC_LENGTH-1:0] pc_ex;
  logic [PC_LENGTH-1:0] actual_pc;
  br_check_type         br_check_if;
  logic [PC_LENGTH-1:0] predicted_pc;

  modport master (
    output stall_if, pc_if, br_update_ex, pc_ex, actual_pc,
    input  br_check_if, predicted_pc
  );

  modport slave (
    input  stall_if, pc_if, br_update_ex, pc_ex, actual_pc,
    output br_check_if, predicted_pc
  );

endinterface : branch_predict_unit_if
`default_nettype wire

// File: rtl/branch_predict_unit_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped branch target buffer, combinational read,
//               synchronous write, no write-to-read bypass.
//   clk, rst_n   : clock, asynchronous active-low reset (valid bits only)
//   rd_pc_i      : lookup PC
//   hit_o        : entry valid and tag matches
//   rd_target_o  : stored target of the indexed entry
//   wr_en_i      : write strobe
//   wr_pc_i      : PC selecting entry and tag to write
//   wr_target_i  : target to store
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int PC_LENGTH    = 32,
  parameter int INDEX_LENGTH = 6
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic [PC_LENGTH-1:0] rd_pc_i,
  output logic                      hit_o,
  output logic [PC_LENGTH-1:0]      rd_target_o,
  input  wire logic                 wr_en_i,
  input  wire logic [PC_LENGTH-1:0] wr_pc_i,
  input  wire logic [PC_LENGTH-1:0] wr_target_i
);

  localparam int DEPTH = 1 << INDEX_LENGTH;
  localparam int TAG_W = PC_LENGTH - INDEX_LENGTH - 2;

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q    [DEPTH];
  logic [PC_LENGTH-1:0] target_q [DEPTH];

  logic [INDEX_LENGTH-1:0] rd_idx;
  logic [INDEX_LENGTH-1:0] wr_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic [TAG_W-1:0]        wr_tag;

  // Instructions are word aligned, so PC[1:0] carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_idx = rd_pc_i[INDEX_LENGTH+1:2];
  assign wr_idx = wr_pc_i[INDEX_LENGTH+1:2];
  assign rd_tag = rd_pc_i[PC_LENGTH-1:INDEX_LENGTH+2];
  assign wr_tag = wr_pc_i[PC_LENGTH-1:INDEX_LENGTH+2];

  assign hit_o       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target_o = target_q[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
    end
  end

endmodule : branch_target_buffer
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Gshare direction predictor (PHT of 2-bit counters indexed by
//               PC XOR global history) combined with a direct-mapped BTB.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : branch_predict_unit_if.slave
//                (stall_if, pc_if, br_update_ex, pc_ex, actual_pc in;
//                 br_check_if, predicted_pc out)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int PC_LENGTH             = 32,
  parameter int GSHARE_HISTORY_LENGTH = branch_predict_unit_pkg::GSHARE_HISTORY_LENGTH,
  parameter int BTB_INDEX_LENGTH      = 6
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  branch_predict_unit_if.slave   bus
);
  import branch_predict_unit_pkg::*;

  localparam int L         = GSHARE_HISTORY_LENGTH;
  localparam int PHT_DEPTH = 1 << L;

  logic [L-1:0]         gbhr_q;
  logic [L-1:0]         gbhr_d;
  logic [1:0]           pht_q [PHT_DEPTH];

  logic [L-1:0]         pht_rd_idx;
  logic [L-1:0]         pht_wr_idx;
  logic [1:0]           pht_rd_val;
  logic                 btb_hit;
  logic [PC_LENGTH-1:0] btb_target;
  logic                 branch_take;
  br_update_type        upd;
  br_check_type         check;

  assign upd = bus.br_update_ex;

  // Read index uses live history; write index uses the history snapshot
  // that was current when the resolving branch was fetched.
  assign pht_rd_idx = bus.pc_if[L+1:2] ^ gbhr_q;
  assign pht_wr_idx = bus.pc_ex[L+1:2] ^ upd.GBHR_old;
  assign pht_rd_val = pht_q[pht_rd_idx];

  branch_target_buffer #(
    .PC_LENGTH    (PC_LENGTH),
    .INDEX_LENGTH (BTB_INDEX_LENGTH)
  ) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_pc_i     (bus.pc_if),
    .hit_o       (btb_hit),
    .rd_target_o (btb_target),
    .wr_en_i     (upd.update && upd.actual),
    .wr_pc_i     (bus.pc_ex),
    .wr_target_i (bus.actual_pc)
  );

  // Without a BTB hit there is no target to redirect to, so the counter
  // alone never causes a taken prediction.
  assign branch_take = btb_hit && pht_rd_val[1];

  assign check.branch_take = branch_take;
  assign check.GBP_predict = pht_rd_val;
  assign check.GBHR        = gbhr_q;

  assign bus.br_check_if  = check;
  assign bus.predicted_pc = branch_take ? btb_target : (bus.pc_if + PC_LENGTH'(4));

  // A mispredict rebuilds history from the fetch-time snapshot plus the
  // real outcome, discarding any speculative shift in the same cycle.
  // Only BTB hits are treated as branches for speculative history.
  always_comb begin
    gbhr_d = gbhr_q;
    if (upd.update && upd.wrong) begin
      gbhr_d = {upd.GBHR_old[L-2:0], upd.actual};
    end else if (btb_hit && !bus.stall_if) begin
      gbhr_d = {gbhr_q[L-2:0], branch_take};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gbhr_q <= '0;
    end else begin
      gbhr_q <= gbhr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= PHT_RESET_VALUE;
      end
    end else if (upd.update) begin
      pht_q[pht_wr_idx] <= upd.GBP_predict_update;
    end
  end

endmodule : branch_predict_unit
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed scoreboard bench for branch_predict_unit. Each step
//               drives one fetch/EX cycle and queues the expected prediction;
//               a monitor compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  logic clk;
  logic rst_n;

  branch_predict_unit_if #(.PC_LENGTH(32)) bus ();

  branch_predict_unit #(
    .PC_LENGTH             (32),
    .GSHARE_HISTORY_LENGTH (8),
    .BTB_INDEX_LENGTH      (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        take;
    logic [1:0]  gbp;
    logic [7:0]  gbhr;
    logic [31:0] ppc;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  mon_e;
  string mon_nm;
  logic  chk_req;
  int    n_run;
  int    n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, expv);
    end
  endtask

  // One cycle of stimulus: inputs change just after the rising edge.
  task automatic step(input logic rst, input logic [31:0] pc, input logic stall,
                      input logic upd, input logic act, input logic wr,
                      input logic [7:0] old, input logic [1:0] gupd,
                      input logic [31:0] pcex, input logic [31:0] apc,
                      input logic etake, input logic [1:0] egbp,
                      input logic [7:0] eghr, input logic [31:0] eppc,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n                               = rst;
    bus.pc_if                           = pc;
    bus.stall_if                        = stall;
    bus.br_update_ex.update             = upd;
    bus.br_update_ex.actual             = act;
    bus.br_update_ex.wrong              = wr;
    bus.br_update_ex.GBHR_old           = old;
    bus.br_update_ex.GBP_predict_update = gupd;
    bus.pc_ex                           = pcex;
    bus.actual_pc                       = apc;
    e.take = etake;
    e.gbp  = egbp;
    e.gbhr = eghr;
    e.ppc  = eppc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL scoreboard: output sampled with no expectation queued");
      end else begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        check(mon_nm, "branch_take",  32'(bus.br_check_if.branch_take), 32'(mon_e.take));
        check(mon_nm, "GBP_predict",  32'(bus.br_check_if.GBP_predict), 32'(mon_e.gbp));
        check(mon_nm, "GBHR",         32'(bus.br_check_if.GBHR),        32'(mon_e.gbhr));
        check(mon_nm, "predicted_pc", bus.predicted_pc,                 mon_e.ppc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_run        = 0;
    n_fail       = 0;
    chk_req      = 1'b0;
    rst_n        = 1'b0;
    bus.pc_if    = 32'h100;
    bus.stall_if = 1'b0;
    bus.br_update_ex = '0;
    bus.pc_ex     = '0;
    bus.actual_pc = '0;

    //    rst  pc         stl upd act wr  old    gupd   pc_ex      actual_pc   take gbp   gbhr   ppc
    step(0, 32'h100,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h00, 32'h104,  "reset");
    step(1, 32'h100,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h00, 32'h104,  "idle_miss");
    // Train 0x100 taken -> 0x200; same-cycle read still sees old state.
    step(1, 32'h100,  0, 1, 1, 1, 8'h00, 2'b10, 32'h100, 32'h200, 0, 2'b01, 8'h00, 32'h104,  "wr_same_cycle");
    // History now 0x01: different PHT entry, BTB hits, not taken.
    step(1, 32'h100,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h01, 32'h104,  "ghr1_other_entry");
    // Aliasing PC: same BTB index, different tag, history must hold at 0x02.
    step(1, 32'h1100, 0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h02, 32'h1104, "btb_alias");
    step(1, 32'h1100, 0, 1, 0, 1, 8'h00, 2'b01, 32'h300, 32'h0,   0, 2'b01, 8'h02, 32'h1104, "alias_no_shift");
    // History restored to 0 by the recovery above: trained entry predicts taken.
    step(1, 32'h100,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   1, 2'b10, 8'h00, 32'h200,  "predict_taken");
    // Recovery loads 0x0F; trains 0x104 -> 0x700 in BTB and PHT[0x46]=11.
    step(1, 32'h500,  0, 1, 1, 1, 8'h07, 2'b11, 32'h104, 32'h700, 0, 2'b01, 8'h01, 32'h504,  "recover_to_0f");
    // Plain update (no wrong): PHT[0x4E]=11, history untouched.
    step(1, 32'h500,  0, 1, 0, 0, 8'h0F, 2'b11, 32'h104, 32'h0,   0, 2'b01, 8'h0F, 32'h504,  "train_4e");
    // Taken hit with concurrent mispredict: recovery wins, history -> 0x06.
    step(1, 32'h104,  0, 1, 0, 1, 8'h03, 2'b01, 32'h800, 32'h0,   1, 2'b11, 8'h0F, 32'h700,  "hit_and_recover");
    // Counter says taken but BTB misses: not taken.
    step(1, 32'h500,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b11, 8'h06, 32'h504,  "pht_taken_btb_miss");
    // Stalled hits for three cycles; first cycle also writes PHT[0x40]=00.
    step(1, 32'h104,  1, 1, 1, 0, 8'h00, 2'b00, 32'h100, 32'h200, 0, 2'b01, 8'h06, 32'h108,  "stall_1");
    step(1, 32'h104,  1, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h06, 32'h108,  "stall_2");
    step(1, 32'h104,  1, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h06, 32'h108,  "stall_3");
    // 0x118 ^ history 0x06 reads PHT[0x40], written during the stall.
    step(1, 32'h118,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b00, 8'h06, 32'h11C,  "stall_pht_written");
    // Reset asserted together with an update: update is discarded.
    step(0, 32'h118,  0, 1, 1, 1, 8'h00, 2'b11, 32'h118, 32'h900, 0, 2'b01, 8'h00, 32'h11C,  "reset_mid_update");
    step(1, 32'h100,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h00, 32'h104,  "post_reset_btb");
    step(1, 32'h118,  0, 0, 0, 0, 8'h00, 2'b00, 32'h0,   32'h0,   0, 2'b01, 8'h00, 32'h11C,  "post_reset_pht");

    @(posedge clk);
    #1;
    chk_req = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard", "pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_branch_predict_unit
`default_nettype wire
